// File: rtl/rca_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract built from one 4-bit ripple-carry adder,
// one nibble per cycle (LSB first), with valid/ready handshakes on both sides.

module rca (
  output logic [3:0] s,
  output logic       cout,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c0
);
  logic [4:0] c;

  assign c[0] = c0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
      assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign cout = c[4];
endmodule

module rca_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] opa_reg, opb_reg, sum_reg, sum_wr;
  logic [IW-1:0]    idx_reg;
  logic             carry_reg, ovf_reg;
  logic [3:0]       opa_nib [NIB];
  logic [3:0]       opb_nib [NIB];
  logic [3:0]       rca_s;
  logic             rca_cout;
  logic             last_nib;

  // Nibble views of the operands; the adder input mux selects by idx.
  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign opa_nib[gi] = opa_reg[4*gi +: 4];
      assign opb_nib[gi] = opb_reg[4*gi +: 4];
      assign sum_wr[4*gi +: 4] = (idx_reg == IW'(gi)) ? rca_s : sum_reg[4*gi +: 4];
    end
  endgenerate

  rca u_rca (
    .s    (rca_s),
    .cout (rca_cout),
    .x    (opa_nib[idx_reg]),
    .y    (opb_nib[idx_reg]),
    .c0   (carry_reg)
  );

  assign last_nib = (idx_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_nib) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa_reg   <= '0;
      opb_reg   <= '0;
      sum_reg   <= '0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            opa_reg   <= a;
            opb_reg   <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            idx_reg   <= '0;
            sum_reg   <= '0;
            ovf_reg   <= 1'b0;
          end
        end
        RUN: begin
          sum_reg   <= sum_wr;
          carry_reg <= rca_cout;
          // Top nibble is being written now, so its MSB comes straight from the adder.
          if (last_nib)
            ovf_reg <= (opa_reg[WIDTH-1] == opb_reg[WIDTH-1]) & (rca_s[3] != opa_reg[WIDTH-1]);
          else
            idx_reg <= idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) & ~rst;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign sum       = sum_reg;
  assign cout      = carry_reg;
  assign ovf       = ovf_reg;
endmodule
